// File: rtl/exe_hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, widths.
package exe_hilo_muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic is_muldiv_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/exe_hilo_muldiv_if.sv
// ID/EXE-side bundle for the HI/LO unit: operation/operands in, HI/LO and status out.
interface exe_hilo_muldiv_if
    import exe_hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [5:0]       in_Operation;
    logic             in_HiLo_Write;
    logic [WIDTH-1:0] in_Read_Data1;
    logic [WIDTH-1:0] in_Read_Data2;
    logic             in_Flush;
    logic [WIDTH-1:0] out_HI;
    logic [WIDTH-1:0] out_LO;
    logic             out_Busy;
    logic             out_Done;

    modport master (
        output in_Operation, in_HiLo_Write, in_Read_Data1, in_Read_Data2, in_Flush,
        input  out_HI, out_LO, out_Busy, out_Done
    );

    modport slave (
        input  in_Operation, in_HiLo_Write, in_Read_Data1, in_Read_Data2, in_Flush,
        output out_HI, out_LO, out_Busy, out_Done
    );
endinterface

// File: rtl/exe_hilo_muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module exe_hilo_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: {hi,lo} is the product/multiplier pair, shifted right each step.
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        // Divide: hi is the remainder, lo shifts the dividend out and the quotient in.
        shifted = {hi_in, lo_in[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        // Only used when ge, where the true difference is below the divisor and fits WIDTH bits.
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            hi_out = ge ? diff : shifted[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], ge};
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/exe_hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; state advances on negedge clk.
module exe_hilo_muldiv
    import exe_hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    exe_hilo_muldiv_if.slave  bus
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo;
    logic             done;

    logic [WIDTH-1:0] hi_acc, lo_acc, opnd;
    logic             is_div, dz, sign_q, sign_r;

    logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic             op_signed, op_div;
    logic             start, step_en, fix_wr, wr_hi, wr_lo;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_signed = ~bus.in_Operation[0];
    assign op_div    = bus.in_Operation[1];
    assign a_mag = (op_signed && bus.in_Read_Data1[WIDTH-1]) ? -bus.in_Read_Data1 : bus.in_Read_Data1;
    assign b_mag = (op_signed && bus.in_Read_Data2[WIDTH-1]) ? -bus.in_Read_Data2 : bus.in_Read_Data2;

    exe_hilo_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi_in   (hi_acc),
        .lo_in   (lo_acc),
        .operand (opnd),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        step_en  = 1'b0;
        fix_wr   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_HiLo_Write) begin
                    if (is_muldiv_op(bus.in_Operation)) begin
                        if (!bus.in_Flush) begin
                            start    = 1'b1;
                            state_nx = op_div ? ST_DIV : ST_MUL;
                        end
                    end else if (bus.in_Operation == OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (bus.in_Operation == OP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.in_Flush) begin
                    state_nx = ST_IDLE;
                end else if (state == ST_DIV && dz) begin
                    state_nx = ST_FIX;
                end else begin
                    step_en = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state_nx = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nx = ST_IDLE;
                fix_wr   = !bus.in_Flush;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sign correction; a divide-by-zero start clears both sign flags so its raw result passes through.
    always_comb begin
        prod_fix = neg_2w({hi_acc, lo_acc}, sign_q);
        if (is_div) begin
            fix_hi = neg_w(hi_acc, sign_r);
            fix_lo = neg_w(lo_acc, sign_q);
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= fix_wr;
            cnt   <= step_en ? cnt + CNT_W'(1) : '0;
            if (fix_wr) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else begin
                if (wr_hi) hi <= bus.in_Read_Data1;
                if (wr_lo) lo <= bus.in_Read_Data1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (start) begin
            is_div <= op_div;
            opnd   <= op_div ? b_mag : a_mag;
            if (op_div && bus.in_Read_Data2 == '0) begin
                dz     <= 1'b1;
                hi_acc <= bus.in_Read_Data1;
                lo_acc <= '1;
                sign_q <= 1'b0;
                sign_r <= 1'b0;
            end else begin
                dz     <= 1'b0;
                hi_acc <= '0;
                lo_acc <= op_div ? a_mag : b_mag;
                sign_q <= op_signed & (bus.in_Read_Data1[WIDTH-1] ^ bus.in_Read_Data2[WIDTH-1]);
                sign_r <= op_signed & bus.in_Read_Data1[WIDTH-1];
            end
        end else if (step_en) begin
            hi_acc <= step_hi;
            lo_acc <= step_lo;
        end
    end

    assign bus.out_HI   = hi;
    assign bus.out_LO   = lo;
    assign bus.out_Busy = (state != ST_IDLE);
    assign bus.out_Done = done;
endmodule
